// File: rtl/uart_reverse_buffer.sv
// LIFO echo buffer between uart_rx and uart_tx: collects DEPTH bytes, then replays them in reverse.
// Optional build macro UART_REV_TERM_EN: a received CR (8'h0D) ends the line early instead of being stored.
module uart_reverse_buffer #(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Busy,
    output logic              o_Overrun
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ZERO  = '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
`ifdef UART_REV_TERM_EN
    localparam logic [7:0]        CR_BYTE   = 8'h0D;
`endif

    logic [7:0]        mem [DEPTH];

    state_t            state_reg,   state_next;
    logic [ADDR_W:0]   count_reg,   count_next;
    logic [ADDR_W-1:0] rd_idx_reg,  rd_idx_next;
    logic              tx_dv_reg,   tx_dv_next;
    logic              busy_reg,    busy_next;
    logic              overrun_reg, overrun_next;
    logic [7:0]        tx_byte_reg;
    logic              mem_we;
    logic              tx_load;

    // State and control registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= ST_FILL;
            count_reg   <= '0;
            rd_idx_reg  <= '0;
            tx_dv_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            rd_idx_reg  <= rd_idx_next;
            tx_dv_reg   <= tx_dv_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
        end
    end

    // Stack storage is deliberately left unreset so it maps onto RAM primitives.
    always_ff @(posedge i_Clock) begin
        if (mem_we) begin
            mem[count_reg[ADDR_W-1:0]] <= i_Rx_Byte;
        end
    end

    // Registered read port; the byte then stays put until the next SEND.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_byte_reg <= 8'h00;
        end else if (tx_load) begin
            tx_byte_reg <= mem[rd_idx_reg];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        rd_idx_next  = rd_idx_reg;
        tx_dv_next   = 1'b0;
        overrun_next = overrun_reg;
        mem_we       = 1'b0;
        tx_load      = 1'b0;

        // Anything arriving while draining is lost, including the cycle of the last Done.
        if (i_Rx_DV && (state_reg != ST_FILL)) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            ST_FILL: begin
                if (i_Rx_DV) begin
`ifdef UART_REV_TERM_EN
                    if (i_Rx_Byte == CR_BYTE) begin
                        if (count_reg != '0) begin
                            rd_idx_next = count_reg[ADDR_W-1:0] - IDX_ONE;
                            state_next  = ST_SEND;
                        end
                    end else
`endif
                    begin
                        mem_we     = 1'b1;
                        count_next = count_reg + CNT_ONE;
                        if ((count_reg + CNT_ONE) == DEPTH_CNT) begin
                            rd_idx_next = LAST_IDX;
                            state_next  = ST_SEND;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (!i_Tx_Active) begin
                    tx_dv_next = 1'b1;
                    tx_load    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_Tx_Done) begin
                    count_next = count_reg - CNT_ONE;
                    if (rd_idx_reg == IDX_ZERO) begin
                        state_next = ST_FILL;
                    end else begin
                        rd_idx_next = rd_idx_reg - IDX_ONE;
                        state_next  = ST_SEND;
                    end
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase

        busy_next = (state_next != ST_FILL);
    end

    // Outputs come straight from registers
    always_comb begin
        o_Tx_DV   = tx_dv_reg;
        o_Tx_Byte = tx_byte_reg;
        o_Count   = count_reg;
        o_Busy    = busy_reg;
        o_Overrun = overrun_reg;
    end

endmodule

// File: doc/uart_reverse_buffer.md
Name: uart_reverse_buffer

Overview:
Sits between uart_rx and uart_tx in the echo path.
- Collects DEPTH received bytes into a small register-file stack.
- Once the stack is full, drains it to uart_tx in reverse (LIFO) order, one byte per transmit handshake.
- Replaces ad-hoc multi-edge buffer logic with a single-clock FSM that respects the o_Tx_Active / o_Tx_Done handshake.

Parameters:
DEPTH, 4, number of bytes collected before the reverse drain starts (2..16)
ADDR_W, $clog2(DEPTH), index width (derived, do not override)

Ports:
i_Clock  input  1  system clock (12 MHz hwclk)
i_Reset  input  1  synchronous, active-high reset
i_Rx_DV  input  1  one-cycle strobe from uart_rx o_Rx_DV
i_Rx_Byte  input  8  byte from uart_rx o_Rx_Byte, valid with i_Rx_DV
o_Tx_DV  output  1  one-cycle start strobe to uart_tx i_Tx_DV
o_Tx_Byte  output  8  byte to uart_tx i_Tx_Byte; stable from o_Tx_DV until i_Tx_Done
i_Tx_Active  input  1  from uart_tx o_Tx_Active
i_Tx_Done  input  1  from uart_tx o_Tx_Done (one-cycle pulse)
o_Count  output  ADDR_W+1  bytes currently held
o_Busy  output  1  high while draining (any state other than FILL)
o_Overrun  output  1  sticky; set when a received byte is dropped

Behaviour:
- One clock (i_Clock). Reset is synchronous and active-high (i_Reset); all state updates on posedge i_Clock.
- Reset values: state=FILL, o_Count=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Overrun=0. Memory contents are not reset.
- Reset mid-drain aborts immediately; uart_tx finishes any byte it has already started.
- FILL state:
  - On i_Rx_DV: mem[o_Count] <= i_Rx_Byte, o_Count++.
  - When this write makes o_Count==DEPTH: set rd_idx=DEPTH-1 and go to SEND on the next cycle.
- SEND state:
  - If i_Tx_Active==0: o_Tx_Byte<=mem[rd_idx], o_Tx_DV<=1 for exactly one cycle, then go to WAIT.
  - If i_Tx_Active==1: hold in SEND with o_Tx_DV=0.
- WAIT state:
  - On i_Tx_Done: o_Count--.
  - If rd_idx==0: go to FILL (o_Count is now 0).
  - Else: rd_idx--, go to SEND.
- Latency: o_Tx_DV rises 2 cycles after the i_Rx_DV that filled the stack (tx idle). Between consecutive bytes there are 2 cycles from i_Tx_Done to the next o_Tx_DV.
- i_Rx_DV outside FILL: the byte is dropped, o_Overrun<=1 (sticky until reset). This includes the same cycle as the final i_Tx_Done; the transition to FILL happens after that cycle, so the byte is still dropped.
- i_Tx_Done outside WAIT is ignored. i_Rx_DV coinciding with the filling write is impossible (single strobe).
- o_Busy = (state != FILL), registered alongside the state.
- No arithmetic wrap: o_Count saturates by construction at 0..DEPTH; rd_idx never underflows.

Optional Feature:
UART_REV_TERM_EN
- Defined: in FILL, i_Rx_DV with i_Rx_Byte==8'h0D (CR) is not stored.
  - If o_Count>0: set rd_idx=o_Count-1 and start the drain early, so a partial line is echoed reversed.
  - If o_Count==0: CR is ignored and the block stays in FILL.
- Not defined: 8'h0D is stored like any other byte; the drain starts only at DEPTH bytes.

Test Plan:
- Reset then 4 rx strobes 'A','B','C','D' (tx model: 104*10-cycle frames) -> o_Tx_DV pulses carry 'D','C','B','A' in order; o_Count steps 4,3,2,1,0; o_Busy drops after the final i_Tx_Done.
- 4 bytes, tx model holds i_Tx_Active=1 for 50 cycles before the first accept -> no o_Tx_DV until Active falls; exactly one pulse per byte.
- During drain, inject i_Rx_DV 0x55 -> byte never transmitted, o_Overrun=1 and stays 1 after return to FILL; next 4 bytes echo normally.
- Assert i_Reset for one cycle after the 2nd byte is sent -> o_Count=0, o_Busy=0, o_Tx_DV=0; next 4 bytes 0x01..0x04 echo as 0x04..0x01.
- DEPTH=8, bytes 0x10..0x17 -> output 0x17 down to 0x10; spurious i_Tx_Done pulses during FILL leave o_Count unchanged.
- With UART_REV_TERM_EN: 'h','i',0x0D -> output 'i','h' only; lone 0x0D at o_Count=0 -> no output. Without the macro: 'h','i',0x0D,'x' -> output 'x',0x0D,'i','h'.
